hcsr04_ranger: RTL and testbench

HCSR04_RANGER -- requirements
Module: hcsr04_ranger

---
 rtl/hcsr04_ranger.sv | 164 ++++++++++++++++
 tb/tb_hcsr04_ranger.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger: issues a trigger pulse, times the echo width in
// microseconds and converts it to millimetres (0.1715 mm/us, Q16 multiply).
// Optional feature macro: HCSR04_RANGER_AUTO_EN -- when defined, HOLDOFF
// returns straight to TRIG so one start gives continuous ranging.
`timescale 1ns/1ps
module hcsr04_ranger #(
  parameter int CLK_MHZ    = 12,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int HOLDOFF_US = 60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        valid,
  output logic [15:0] echo_us,
  output logic [15:0] distance_mm,
  output logic        timeout
);

  localparam logic [7:0]  PRE_MAX   = 8'(CLK_MHZ - 1);
  localparam logic [15:0] TRIG_LAST = 16'(TRIG_US * CLK_MHZ - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] TO_FULL   = 16'(TIMEOUT_US);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_US - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, CALC, HOLDOFF} state_t;

`ifdef HCSR04_RANGER_AUTO_EN
  localparam state_t HOLD_EXIT = TRIG;
`else
  localparam state_t HOLD_EXIT = IDLE;
`endif

  state_t      state_q, state_d;
  logic        echo_s1_q, echo_s2_q, echo_s3_q;
  logic [7:0]  pre_q;
  logic [15:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [15:0] echo_us_q, echo_us_d;
  logic [15:0] dist_q, dist_d;
  logic        to_q, to_d;
  logic        tick, rise, fall;

  // Echo width (us) to millimetres: 11239/65536 ~= 0.1715 mm/us.
  function automatic logic [15:0] mm_from_us(input logic [15:0] us);
    return 16'((32'(us) * 32'd11239) >> 16);
  endfunction

  assign tick = (pre_q == PRE_MAX);
  assign rise = echo_s2_q & ~echo_s3_q;
  assign fall = ~echo_s2_q & echo_s3_q;

  assign trig        = (state_q == TRIG);
  assign busy        = (state_q != IDLE);
  assign valid       = valid_q;
  assign echo_us     = echo_us_q;
  assign distance_mm = dist_q;
  assign timeout     = to_q;

  // State, synchronizer, prescaler and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
      pre_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      echo_us_q <= '0;
      dist_q    <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
      // The us grid is re-aligned to every state entry.
      pre_q     <= (state_d != state_q || tick) ? '0 : pre_q + 8'd1;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      echo_us_q <= echo_us_d;
      dist_q    <= dist_d;
      to_q      <= to_d;
    end
  end

  // Next-state logic, shared cycle/us counter and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    echo_us_d = echo_us_q;
    dist_d    = dist_q;
    to_d      = to_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_RISE: begin
        // Only a fresh low-to-high edge starts timing; a level already high is ignored.
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == TO_LAST) state_d = CALC;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_d = CALC;
        end else if (tick && echo_s2_q) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == TO_LAST) state_d = CALC;
        end
      end
      CALC: begin
        // A counter sitting at the full timeout value can only come from a timeout exit.
        valid_d   = 1'b1;
        echo_us_d = cnt_q;
        if (cnt_q == TO_FULL) begin
          dist_d = 16'hFFFF;
          to_d   = 1'b1;
        end else begin
          dist_d = mm_from_us(cnt_q);
          to_d   = 1'b0;
        end
        state_d = HOLDOFF;
        cnt_d   = '0;
      end
      HOLDOFF: begin
        if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = HOLD_EXIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Scoreboard bench for hcsr04_ranger, run with a scaled-down clock and
// timeout so every scenario fits a short simulation.
`timescale 1ns/1ps
module tb_hcsr04_ranger;

  localparam int C     = 2;
  localparam int T_US  = 10;
  localparam int TO_US = 6000;
  localparam int HO_US = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        echo = 1'b0;
  logic        trig, busy, valid, timeout;
  logic [15:0] echo_us, distance_mm;

  always #5 clk = ~clk;

  hcsr04_ranger #(
    .CLK_MHZ(C), .TRIG_US(T_US), .TIMEOUT_US(TO_US), .HOLDOFF_US(HO_US)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig),
    .busy(busy), .valid(valid), .echo_us(echo_us),
    .distance_mm(distance_mm), .timeout(timeout)
  );

  typedef struct {int us; int mm; int to; int tol;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int trig_rises = 0;
  logic trig_prev = 1'b0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // Monitor: pops the scoreboard on each new result and watches pulse shapes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (trig && !trig_prev) trig_rises++;
        if (valid_prev) check("valid_one_cycle", int'(valid), 0, 0);
        if (valid && !valid_prev) begin
          valid_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid with echo_us=%0d, expected none", echo_us);
          end else begin
            e = sb.pop_front();
            check("echo_us", int'(echo_us), e.us, e.tol);
            check("distance_mm", int'(distance_mm), e.mm, 0);
            check("timeout", int'(timeout), e.to, 0);
          end
        end
      end
      trig_prev  = trig;
      valid_prev = valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Follows a start pulse: measures the trigger width; returns on the first trig-low cycle.
  task automatic trig_pulse();
    int w = 0;
    int g = 0;
    int busy_ok = 1;
    while (!trig && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("trig_seen", int'(trig), 1, 0);
    while (trig && w < 1000) begin
      if (!busy) busy_ok = 0;
      w++;
      @(negedge clk);
    end
    check("trig_width", w, C * T_US, 0);
    check("busy_during_trig", busy_ok, 1, 0);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check(name, int'(busy), 0, 0);
  endtask

  // Cycles from the current point until valid, bounded.
  task automatic cycles_to_valid(output int n);
    n = 0;
    while (!valid && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_trig"}, int'(trig), 0, 0);
    check({tag, "_busy"}, int'(busy), 0, 0);
    check({tag, "_valid"}, int'(valid), 0, 0);
    check({tag, "_timeout"}, int'(timeout), 0, 0);
    check({tag, "_echo_us"}, int'(echo_us), 0, 0);
    check({tag, "_distance"}, int'(distance_mm), 0, 0);
  endtask

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    int v0;
    rst = 1'b1;
    tick(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(3);

`ifdef HCSR04_RANGER_AUTO_EN
    // One start, then the ranger keeps re-triggering after each holdoff.
    sb.push_back('{us: 1000, mm: 171, to: 0, tol: 1});
    pulse_start();
    trig_pulse();
    tick(10);
    echo = 1'b1;
    tick(1000 * C);
    echo = 1'b0;
    cycles_to_valid(n);
    check("auto_valid_seen", int'(valid), 1, 0);
    n = 0;
    while (!trig && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("auto_retrigger_gap", n, HO_US * C, 0);
    sb.push_back('{us: TO_US, mm: 16'hFFFF, to: 1, tol: 0});
    trig_pulse();
    cycles_to_valid(n);
    check("auto_timeout_latency", n, TO_US * C, 2);
    tick(HO_US * C + 10);
    check("auto_third_trig", trig_rises, 3, 0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
`else
    // 1000 us echo with stray start pulses in MEASURE and HOLDOFF.
    r0 = trig_rises;
    v0 = valid_cnt;
    sb.push_back('{us: 1000, mm: 171, to: 0, tol: 1});
    pulse_start();
    trig_pulse();
    tick(10);
    echo = 1'b1;
    tick(1000);
    pulse_start();
    tick(1000 * C - 1002);
    echo = 1'b0;
    tick(10);
    check("busy_in_holdoff", int'(busy), 1, 0);
    check("valid_count_A", valid_cnt - v0, 1, 0);
    pulse_start();
    wait_idle("idle_after_A");
    tick(5);
    check("no_extra_trig", trig_rises - r0, 1, 0);
    check("idle_after_stray_start", int'(busy), 0, 0);

    // 5830 us echo -> 999 mm.
    sb.push_back('{us: 5830, mm: 999, to: 0, tol: 1});
    pulse_start();
    trig_pulse();
    tick(7);
    echo = 1'b1;
    tick(5830 * C);
    echo = 1'b0;
    wait_idle("idle_after_B");

    // Echo never rises.
    sb.push_back('{us: TO_US, mm: 16'hFFFF, to: 1, tol: 0});
    pulse_start();
    trig_pulse();
    cycles_to_valid(n);
    check("rise_timeout_latency", n, TO_US * C, 2);
    wait_idle("idle_after_C");

    // Echo stuck high from before the trigger.
    echo = 1'b1;
    tick(3);
    sb.push_back('{us: TO_US, mm: 16'hFFFF, to: 1, tol: 0});
    pulse_start();
    trig_pulse();
    cycles_to_valid(n);
    check("stuck_high_latency", n, TO_US * C, 2);
    wait_idle("idle_after_D");
    echo = 1'b0;
    tick(5);

    // Reset during TRIG: trig must drop right after the reset edge.
    pulse_start();
    tick(5);
    check("trig_before_rst", int'(trig), 1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("trig_after_rst", int'(trig), 0, 0);
    rst = 1'b0;
    tick(3);

    // Reset mid-MEASURE: no result, outputs back to reset values.
    v0 = valid_cnt;
    pulse_start();
    trig_pulse();
    tick(10);
    echo = 1'b1;
    tick(1000);
    rst = 1'b1;
    tick(2);
    check_reset_outputs("abort");
    rst = 1'b0;
    tick(500);
    echo = 1'b0;
    tick(300);
    check("abort_no_valid", valid_cnt - v0, 0, 0);
    check("abort_idle", int'(busy), 0, 0);
`endif

    check("scoreboard_drained", sb.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
